// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   - parity mode constants (PARITY_NONE / PARITY_ODD / PARITY_EVEN)
//   - transmit FSM state encoding (uart_state_t)
//   - cycles_per_bit(): clock cycles spent on each serial bit
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Integer floor of clk_hz / bit_rate; callers rely on the result being >= 2.
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered_if
// Write port of the buffered UART transmitter.
//   tx_data  : word to enqueue (PAYLOAD_BITS wide)
//   tx_valid : producer holds tx_data valid
//   tx_ready : transmitter FIFO can accept a word
//
// Handshake: a word transfers on every rising clock edge where
// tx_valid && tx_ready. tx_ready never depends on tx_valid. While tx_ready
// is low the producer keeps tx_valid/tx_data stable; nothing is dropped.
// -----------------------------------------------------------------------------
interface uart_tx_buffered_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic [PAYLOAD_BITS-1:0] tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous circular-buffer FIFO feeding the UART transmit FSM.
//   clk, reset : system clock, asynchronous active-high reset
//   push, din  : enqueue din (ignored while full)
//   pop, dout  : dequeue; dout always shows the head word (show-ahead)
//   count      : words currently stored
//   full/empty : derived from count
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Guarded locally as well, so a misbehaving caller cannot corrupt count.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through valid entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// Buffered UART transmitter: a FIFO absorbs words from a valid/ready write
// port and a frame FSM serialises them (start, LSB-first data, optional
// parity, 1 or 2 stop bits) with no idle gap between queued frames.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   tx_if        : write port (tx_data / tx_valid / tx_ready), slave side
//   fifo_count   : words queued, not counting the word being transmitted
//   uart_tx_busy : FSM active or FIFO non-empty
//   uart_txd     : registered serial output, idles high
//   fsm_state    : current FSM state, for observation
// -----------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_buffered_if.slave           tx_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        uart_tx_busy,
    output logic                        uart_txd,
    output uart_state_t                 fsm_state
);

    localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BW  = 4;  // enough to index up to 9 data bits

    // FIFO connections
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [PAYLOAD_BITS-1:0] fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;

    // FSM and datapath registers
    uart_state_t             state_q, state_d;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    txd_q, txd_d;

    logic                    bit_end;
    logic                    head_parity;

    assign tx_if.tx_ready = !fifo_full;
    assign fifo_push      = tx_if.tx_valid && !fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tx_if.tx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Parity of the word about to be popped; latched together with the load.
    assign head_parity = (PARITY_MODE == PARITY_ODD) ? ~^fifo_dout : ^fifo_dout;

    assign bit_end = (cyc_q == CW'(CPB - 1));

    // ---------------- next-state / datapath logic ----------------
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    par_d    = head_parity;
                    cyc_d    = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end

            START: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(PAYLOAD_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            PARITY: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = STOP;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    cyc_d = '0;
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // Chain straight into the next frame when a word is
                        // waiting, so queued frames leave no idle gap.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_dout;
                            par_d    = head_parity;
                            state_d  = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the current state; registered below so uart_txd is
    // glitch-free and lags the state by one cycle.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            PARITY:  txd_d = par_q;
            default: txd_d = 1'b1;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end

    assign uart_txd     = txd_q;
    assign uart_tx_busy = (state_q != IDLE) || !fifo_empty;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
// Four transmitter instances (CPB = 10) run side by side:
//   inst0: 8N1, FIFO depth 4     inst1: 8E1, depth 16
//   inst2: 8O1, depth 16         inst3: 7N2, depth 16
// Each instance has a frame-level reference model (queue of words, frame
// built as a bit list) compared against the DUT on every negative edge.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;
    import uart_pkg::*;

    localparam int CPB = 10;
    localparam int PB_T  [4] = '{8, 8, 8, 7};
    localparam int PM_T  [4] = '{0, 2, 1, 0};
    localparam int SB_T  [4] = '{1, 1, 1, 2};
    localparam int DEP_T [4] = '{4, 16, 16, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]      rst_w;
    logic [3:0]      drv_valid;
    logic [3:0][8:0] drv_data;
    logic [3:0]      txd_w;
    logic [3:0]      busy_w;
    logic [3:0]      rdy_w;
    logic [3:0][4:0] cnt_w;
    logic            chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, inst, act, exp, $time);
        end
    endtask

    // ---------------- instances + reference models ----------------
    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int PB   = PB_T[g];
        localparam int PM   = PM_T[g];
        localparam int SB   = SB_T[g];
        localparam int DEP  = DEP_T[g];
        localparam int FLEN = CPB * (1 + PB + ((PM != 0) ? 1 : 0) + SB);

        uart_tx_buffered_if #(.PAYLOAD_BITS(PB)) bus ();
        logic [$clog2(DEP):0] cnt;
        uart_state_t          st;
        logic                 rst_g;

        assign rst_g        = rst_w[g];
        assign bus.tx_data  = drv_data[g][PB-1:0];
        assign bus.tx_valid = drv_valid[g];
        assign rdy_w[g]     = bus.tx_ready;
        assign cnt_w[g]     = 5'(cnt);

        uart_tx_buffered #(
            .CLK_HZ       (1_000_000),
            .BIT_RATE     (100_000),
            .PAYLOAD_BITS (PB),
            .PARITY_MODE  (PM),
            .STOP_BITS    (SB),
            .FIFO_DEPTH   (DEP)
        ) dut (
            .clk          (clk),
            .reset        (rst_g),
            .tx_if        (bus),
            .fifo_count   (cnt),
            .uart_tx_busy (busy_w[g]),
            .uart_txd     (txd_w[g]),
            .fsm_state    (st)
        );

        // Model: words wait in mq; the word on the line is a list of frame
        // bits, t counts cycles since it was popped.
        logic [8:0] mq [$];
        bit         act    = 1'b0;
        int         t      = 0;
        logic       fb [16];
        logic       e_txd  = 1'b1;
        logic       e_rdy  = 1'b1;
        logic       e_busy = 1'b0;
        int         e_cnt  = 0;
        logic       m_line;
        bit         m_push;
        logic [8:0] m_word;
        int         m_n;
        int         m_ones;

        always @(posedge clk or posedge rst_g) begin
            if (rst_g) begin
                mq.delete();
                act    = 1'b0;
                t      = 0;
                e_txd  = 1'b1;
                e_rdy  = 1'b1;
                e_busy = 1'b0;
                e_cnt  = 0;
            end else begin
                m_line = act ? fb[t / CPB] : 1'b1;
                m_push = drv_valid[g] && (mq.size() < DEP);
                if (!act || t == FLEN - 1) begin
                    if (mq.size() > 0) begin
                        m_word = mq.pop_front();
                        fb[0]  = 1'b0;
                        for (int i = 0; i < PB; i++) fb[1 + i] = m_word[i];
                        m_n = 1 + PB;
                        if (PM != 0) begin
                            m_ones = $countones(m_word);
                            fb[m_n] = (PM == 2) ? (m_ones % 2 == 1) : (m_ones % 2 == 0);
                            m_n++;
                        end
                        for (int i = 0; i < SB; i++) fb[m_n + i] = 1'b1;
                        act = 1'b1;
                        t   = 0;
                    end else begin
                        act = 1'b0;
                        t   = 0;
                    end
                end else begin
                    t++;
                end
                if (m_push) mq.push_back(drv_data[g] & 9'((1 << PB) - 1));
                e_txd  = m_line;
                e_cnt  = mq.size();
                e_rdy  = (mq.size() < DEP);
                e_busy = act || (mq.size() > 0);
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check("txd",        g, 32'(txd_w[g]),  32'(e_txd));
                check("fifo_count", g, 32'(cnt_w[g]),  e_cnt);
                check("tx_ready",   g, 32'(rdy_w[g]),  32'(e_rdy));
                check("busy",       g, 32'(busy_w[g]), 32'(e_busy));
                check("fsm_idle",   g, 32'(st == IDLE), 32'(!act));
            end
        end
    end

    // ---------------- driver / directed scenarios ----------------
    logic [3:0] cap_l [320];
    logic [3:0] cap_b [320];
    logic [4:0] cap_c [320];
    logic       a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int         peak;
    int         acc, cyc, drop_at, rise_at, acc_at_drop, lows, thr;
    logic       rdy_before;
    logic [8:0] cur;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic capture(input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            step();
            cap_l[k] = txd_w;
            cap_b[k] = busy_w;
            cap_c[k] = cnt_w[3];
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy_w != 4'b0; i++) step();
        check("idle_timeout", 0, 32'(busy_w), 32'd0);
    endtask

    initial begin
        rst_w     = 4'hF;
        drv_valid = 4'h0;
        drv_data  = '0;
        repeat (3) step();
        for (int g = 0; g < 4; g++) begin
            check("rst_txd",   g, 32'(txd_w[g]),  32'd1);
            check("rst_ready", g, 32'(rdy_w[g]),  32'd1);
            check("rst_count", g, 32'(cnt_w[g]),  32'd0);
            check("rst_busy",  g, 32'(busy_w[g]), 32'd0);
        end
        rst_w  = 4'h0;
        chk_en = 1'b1;
        step();

        // Single byte 0xA5 on 8N1.
        drv_data[0]  = 9'h0A5;
        drv_valid[0] = 1'b1;
        step();
        drv_valid[0] = 1'b0;
        capture(1, 112);
        check("a_idle_k1",   0, 32'(cap_l[1][0]),  32'd1);
        check("a_start_k2",  0, 32'(cap_l[2][0]),  32'd0);
        check("a_start_k11", 0, 32'(cap_l[11][0]), 32'd0);
        for (int i = 0; i < 8; i++)
            check("a_data_bit", 0, 32'(cap_l[17 + 10 * i][0]), 32'(a5_bits[i]));
        check("a_stop",      0, 32'(cap_l[97][0]),  32'd1);
        check("a_busy_k100", 0, 32'(cap_b[100][0]), 32'd1);
        check("a_busy_k101", 0, 32'(cap_b[101][0]), 32'd0);

        // Parity: 0x07 into 8E1 (inst1) and 8O1 (inst2).
        drv_data[1]  = 9'h007;
        drv_data[2]  = 9'h007;
        drv_valid[1] = 1'b1;
        drv_valid[2] = 1'b1;
        step();
        drv_valid[1] = 1'b0;
        drv_valid[2] = 1'b0;
        capture(1, 112);
        check("b_even_parity", 1, 32'(cap_l[97][1]),  32'd1);
        check("b_odd_parity",  2, 32'(cap_l[97][2]),  32'd0);
        check("b_data_bit2",   1, 32'(cap_l[37][1]),  32'd1);
        check("b_data_bit3",   2, 32'(cap_l[47][2]),  32'd0);
        check("b_stop",        1, 32'(cap_l[106][1]), 32'd1);
        check("b_busy_k110",   1, 32'(cap_b[110][1]), 32'd1);
        check("b_busy_k111",   1, 32'(cap_b[111][1]), 32'd0);
        check("b_busy_k110",   2, 32'(cap_b[110][2]), 32'd1);
        check("b_busy_k111",   2, 32'(cap_b[111][2]), 32'd0);

        // Back-to-back 7N2: 0x11, 0x22, 0x33 on consecutive cycles.
        drv_valid[3] = 1'b1;
        drv_data[3]  = 9'h011;
        step();
        drv_data[3]  = 9'h022;
        capture(1, 1);
        drv_data[3]  = 9'h033;
        capture(2, 2);
        drv_valid[3] = 1'b0;
        capture(3, 305);
        peak = 0;
        for (int k = 1; k <= 305; k++) if (int'(cap_c[k]) > peak) peak = int'(cap_c[k]);
        check("c_count_peak",  3, peak, 32'd2);
        check("c_stop2_f1",    3, 32'(cap_l[95][3]),  32'd1);
        check("c_last_stop_f1",3, 32'(cap_l[101][3]), 32'd1);
        check("c_start_f2",    3, 32'(cap_l[102][3]), 32'd0);
        check("c_f2_bit0",     3, 32'(cap_l[117][3]), 32'd0);
        check("c_f2_bit1",     3, 32'(cap_l[127][3]), 32'd1);
        check("c_last_stop_f2",3, 32'(cap_l[201][3]), 32'd1);
        check("c_start_f3",    3, 32'(cap_l[202][3]), 32'd0);
        check("c_f3_bit0",     3, 32'(cap_l[217][3]), 32'd1);
        check("c_busy_k300",   3, 32'(cap_b[300][3]), 32'd1);
        check("c_busy_k301",   3, 32'(cap_b[301][3]), 32'd0);

        // FIFO full on depth 4: hold valid with incrementing data.
        wait_idle(3000);
        acc = 0; cyc = 0; drop_at = -1; rise_at = -1; acc_at_drop = -1;
        cur = 9'h040;
        drv_data[0]  = cur;
        drv_valid[0] = 1'b1;
        while (acc < 12 && cyc < 2000) begin
            rdy_before = rdy_w[0];
            step();
            cyc++;
            if (rdy_before) begin
                acc++;
                cur = cur + 9'd1;
                drv_data[0] = cur;
            end
            if (!rdy_w[0] && drop_at < 0) begin
                drop_at     = cyc;
                acc_at_drop = acc;
            end
            if (rdy_w[0] && drop_at >= 0 && rise_at < 0) rise_at = cyc;
        end
        drv_valid[0] = 1'b0;
        check("d_accepts_at_full", 0, acc_at_drop, 32'd5);
        check("d_ready_low_cycles", 0, rise_at - drop_at, 32'd97);
        check("d_all_accepted", 0, acc, 32'd12);
        wait_idle(3000);

        // Reset during DATA bit 3 with two words queued.
        drv_valid[0] = 1'b1;
        drv_data[0]  = 9'h000;
        step();
        drv_data[0]  = 9'h05A;
        step();
        drv_data[0]  = 9'h03C;
        step();
        drv_valid[0] = 1'b0;
        repeat (44) step();
        check("e_pre_txd",   0, 32'(txd_w[0]), 32'd0);
        check("e_pre_count", 0, 32'(cnt_w[0]), 32'd2);
        rst_w[0] = 1'b1;
        #1;
        check("e_async_txd",   0, 32'(txd_w[0]),  32'd1);
        check("e_async_count", 0, 32'(cnt_w[0]),  32'd0);
        check("e_async_busy",  0, 32'(busy_w[0]), 32'd0);
        check("e_async_ready", 0, 32'(rdy_w[0]),  32'd1);
        repeat (2) step();
        rst_w[0] = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lows++;
        end
        check("e_quiet_after_reset", 0, lows, 32'd0);

        // Randomised traffic on all instances, alternating light and heavy load.
        for (int c = 0; c < 4000; c++) begin
            thr = ((c / 500) % 2 == 0) ? 2 : 40;
            for (int g = 0; g < 4; g++) begin
                drv_valid[g] = ($urandom_range(0, 99) < thr);
                drv_data[g]  = 9'($urandom_range(0, 511));
            end
            step();
        end
        drv_valid = 4'h0;
        wait_idle(5000);
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 5000000", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised successor to the single-byte UART transmitter. Adds a synchronous transmit FIFO with a valid/ready write port, configurable data width, parity and stop bits, and back-to-back frame emission with no idle gap. It sits between any byte-producing logic (the test algorithm, debug dumpers) and the board UART TX pin.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency in Hz.
- `BIT_RATE`, 115200: line rate in bits/s. `CYCLES_PER_BIT = CLK_HZ / BIT_RATE` (integer floor), must be ≥ 2.
- `PAYLOAD_BITS`, 8: data bits per frame, legal range 5–9.
- `PARITY_MODE`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries, power of two, ≥ 2.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `tx_data` in PAYLOAD_BITS: word to enqueue.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO can accept a word (`!full`).
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of words queued, excluding the word in flight.
- `uart_tx_busy` out 1: FSM not IDLE or FIFO non-empty.
- `uart_txd` out 1: serial line, registered.

## Operation
- Write handshake:
  - A word is accepted on a rising edge where `tx_valid && tx_ready`.
  - When `tx_ready` is 0, `tx_valid` is ignored. Nothing is dropped and nothing is flagged.
- FSM states and transitions:
  - IDLE → START when the FIFO is non-empty. This pops the head word into the shift register and latches parity.
  - START: 1 bit-time.
  - DATA: PAYLOAD_BITS bit-times, LSB first.
  - PARITY: 1 bit-time, only when PARITY_MODE ≠ 0.
  - STOP: STOP_BITS bit-times.
  - At the end of STOP:
    - FIFO non-empty → START directly, popping the next word.
    - FIFO empty → IDLE.
- Parity bit:
  - Even: `^data`.
  - Odd: `~^data`.
  - Computed on the popped word.
- Line levels:
  - IDLE and STOP: 1.
  - START: 0.
  - DATA: shift register bit 0.
  - PARITY: the latched parity bit.
- Bit timing:
  - The bit counter runs 0..CYCLES_PER_BIT-1.
  - Each bit holds for exactly CYCLES_PER_BIT cycles.
- FIFO:
  - Circular buffer with wrapping read and write pointers.
  - Full and empty are derived from `fifo_count`.
  - Simultaneous push and pop leaves the count unchanged.
  - A push while full cannot occur (`tx_ready` = 0).
  - A pop while empty cannot occur (the FSM only pops when the FIFO is non-empty).

## Timing
- Reset values, asserted asynchronously:
  - `uart_txd` = 1, `tx_ready` = 1, `fifo_count` = 0, `uart_tx_busy` = 0.
  - FSM = IDLE, pointers = 0.
- Reset mid-frame: the frame is abandoned, `uart_txd` returns to 1 immediately, and FIFO contents are discarded.
- Latency:
  - Word accepted at edge N into an empty FIFO with the FSM in IDLE.
  - Edge N+1: pop and FSM → START.
  - Edge N+2: `uart_txd` = 0 (`uart_txd` registered from current state).
- Frame length is `CYCLES_PER_BIT × (1 + PAYLOAD_BITS + (PARITY_MODE≠0) + STOP_BITS)`.
- Consecutive frames have zero idle cycles between them.
- `fifo_count`:
  - Increments the cycle after a push.
  - Decrements the cycle after a pop.
- `tx_ready` deasserts the cycle after the push that fills the FIFO.

## Structure
- Package `uart_pkg`:
  - Parity mode constants (PARITY_NONE/ODD/EVEN).
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Function `cycles_per_bit(clk_hz, bit_rate)`.
- Sub-module `uart_tx_fifo`:
  - Parameters: DEPTH, WIDTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same clock and asynchronous reset as the parent.
- The top level instantiates the FIFO and holds the FSM, bit counter, cycle counter and shift register.

## Test plan
All scenarios use CLK_HZ = 1_000_000 and BIT_RATE = 100_000, so CYCLES_PER_BIT = 10.

- Single byte, 8N1:
  - Stimulus: push 0xA5 while idle.
  - Required response: `uart_txd` low 2 cycles after acceptance, then 1,0,1,0,0,1,0,1 at 10 cycles each, stop 10 cycles high, `uart_tx_busy` 0 after 100 cycles of frame.
- Parity, 8E1 and 8O1:
  - Stimulus: push 0x07.
  - Required response: even gives parity bit 1, odd gives 0; frame length 110 cycles.
- Back-to-back, 7N2:
  - Stimulus: push 0x11, 0x22, 0x33 on consecutive cycles.
  - Required response: three 100-cycle frames with no idle gap; `fifo_count` peaks at 2 (word 1 popped).
- FIFO full, FIFO_DEPTH = 4:
  - Stimulus: hold `tx_valid` with incrementing data.
  - Required response: `tx_ready` drops after 5 accepts (4 queued + 1 in flight), reasserts on the next pop; every value is transmitted in order with none lost.
- Reset mid-frame:
  - Stimulus: assert `reset` during DATA bit 3 with 2 words queued.
  - Required response: `uart_txd` = 1 and `fifo_count` = 0 asynchronously; after release there is no further transmission until a new push.
